// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with a selectable read mode (registered or FWFT), programmable
// almost-full/almost-empty watermarks, an occupancy count, sticky error flags and a flush.
module sync_fifo_prog #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 64,
    parameter int FWFT       = 0,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic [PTR_WIDTH:0]    af_thresh,
    input  logic [PTR_WIDTH:0]    ae_thresh,
    output logic [PTR_WIDTH:0]    fill_count,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0]   DEPTH_C = FIFO_DEPTH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = 1;
    localparam logic [PTR_WIDTH:0]   CNT_ONE = 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wptr, rptr;
    logic [PTR_WIDTH:0]    count;
    logic                  rd_ok, wr_ok, rd_acc, wr_acc;

    assign fill_count   = count;
    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == DEPTH_C);
    assign almost_full  = (count >= af_thresh);
    assign almost_empty = (count <= ae_thresh);

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    assign rd_ok  = rd_en & ~fifo_empty;
    assign wr_ok  = wr_en & (~fifo_full | rd_ok);
    assign rd_acc = rd_ok & ~flush;
    assign wr_acc = wr_ok & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc) wptr <= wptr + PTR_ONE;
            if (rd_acc) rptr <= rptr + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= data_in;
    end

    // Set beats clear; a flush cycle leaves both flags untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            if (wr_en && !wr_ok)  overflow <= 1'b1;
            else if (clr_err)     overflow <= 1'b0;
            if (rd_en && !rd_ok)  underflow <= 1'b1;
            else if (clr_err)     underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rptr];
        end else begin : g_reg
            logic [FIFO_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      dout_q <= '0;
                else if (rd_acc) dout_q <= mem[rptr];
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed bench for sync_fifo_prog: a registered-read and an FWFT instance share stimulus,
// and a queue scoreboard predicts data, count, watermarks and sticky flags.
module tb_sync_fifo_prog;

    localparam int DEPTH = 8;
    localparam int W     = 16;
    localparam int PW    = $clog2(DEPTH);

    logic          clk = 0;
    logic          rst_n = 0;
    logic          wr_en = 0, rd_en = 0, flush = 0, clr_err = 0;
    logic [W-1:0]  data_in = '0;
    logic [PW:0]   af = '0, ae = 4'd2;

    logic [W-1:0]  dout0, dout1;
    logic [PW:0]   fc0, fc1;
    logic          full0, empty0, afull0, aempty0, ovf0, unf0;
    logic          full1, empty1, afull1, aempty1, ovf1, unf1;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] last_rd = '0;
    logic         m_ovf = 0, m_unf = 0;

    sync_fifo_prog #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(W), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout0), .flush(flush), .clr_err(clr_err), .af_thresh(af), .ae_thresh(ae),
        .fill_count(fc0), .fifo_full(full0), .fifo_empty(empty0), .almost_full(afull0),
        .almost_empty(aempty0), .overflow(ovf0), .underflow(unf0));

    sync_fifo_prog #(.FIFO_DEPTH(DEPTH), .FIFO_WIDTH(W), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout1), .flush(flush), .clr_err(clr_err), .af_thresh(af), .ae_thresh(ae),
        .fill_count(fc1), .fifo_full(full1), .fifo_empty(empty1), .almost_full(afull1),
        .almost_empty(aempty1), .overflow(ovf1), .underflow(unf1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = q.size();
        chk("fill_count",   32'(fc0),    32'(n));
        chk("fifo_full",    32'(full0),  32'(n == DEPTH));
        chk("fifo_empty",   32'(empty0), 32'(n == 0));
        chk("almost_full",  32'(afull0), 32'(n >= int'(af)));
        chk("almost_empty", 32'(aempty0),32'(n <= int'(ae)));
        chk("overflow",     32'(ovf0),   32'(m_ovf));
        chk("underflow",    32'(unf0),   32'(m_unf));
        chk("dout_reg",     32'(dout0),  32'(last_rd));
        chk("fwft_count",   32'(fc1),    32'(n));
        chk("fwft_empty",   32'(empty1), 32'(n == 0));
        chk("fwft_ovf",     32'(ovf1),   32'(m_ovf));
    endtask

    // One clock of stimulus; caller sits just after a rising edge.
    task automatic cyc(input logic w, input logic [W-1:0] d, input logic r,
                       input logic fl = 1'b0, input logic ce = 1'b0);
        bit ra, wa;
        if (q.size() != 0) chk("fwft_dout", 32'(dout1), 32'(q[0]));
        ra = r && (q.size() != 0);
        wa = w && ((q.size() != DEPTH) || ra);
        wr_en = w; data_in = d; rd_en = r; flush = fl; clr_err = ce;
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
        if (fl) q.delete();
        else begin
            if (ra) last_rd = q.pop_front();
            if (wa) q.push_back(d);
            if (w && !wa) m_ovf = 1; else if (ce) m_ovf = 0;
            if (r && !ra) m_unf = 1; else if (ce) m_unf = 0;
        end
        check_state();
    endtask

    task automatic check_reset_vals();
        chk("rst_fill",   32'(fc0),     32'd0);
        chk("rst_empty",  32'(empty0),  32'd1);
        chk("rst_full",   32'(full0),   32'd0);
        chk("rst_aempty", 32'(aempty0), 32'd1);
        chk("rst_afull",  32'(afull0),  32'(af == 0));
        chk("rst_ovf",    32'(ovf0),    32'd0);
        chk("rst_unf",    32'(unf0),    32'd0);
        chk("rst_dout",   32'(dout0),   32'd0);
        chk("rst_fill1",  32'(fc1),     32'd0);
    endtask

    initial begin
        // Reset with af_thresh = 0 so almost_full is expected high from reset.
        #1 check_reset_vals();
        #12 rst_n = 1;
        @(posedge clk); #1;
        af = 4'd6; ae = 4'd2;

        // 1: fill to full then drain, data in order with one-cycle read latency
        for (int i = 1; i <= 8; i++) cyc(1, W'(i), 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1);

        // 2: overflow on full, then simultaneous write+read on full
        for (int i = 0; i < 8; i++) cyc(1, W'(16'h0011 + i), 0);
        cyc(1, 16'hBEEF, 0);
        cyc(1, 16'h00AA, 1);
        cyc(0, '0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1);

        // 3: underflow, set beats clear, then clear alone
        cyc(0, '0, 1);
        cyc(0, '0, 1, 0, 1);
        cyc(0, '0, 0, 0, 1);
        cyc(1, 16'h0C0C, 1);
        cyc(0, '0, 0, 0, 1);
        cyc(0, '0, 1);

        // 4: watermark sweep, then wrapped interleaved traffic
        for (int i = 0; i < 8; i++) cyc(1, W'(16'h0200 + i), 0);
        for (int i = 0; i < 8; i++) cyc(0, '0, 1);
        for (int i = 0; i < 20; i++) cyc(1, W'(16'h0100 + i), (i % 3) != 0);
        while (q.size() != 0) cyc(0, '0, 1);

        // Threshold boundaries take effect combinationally
        af = 4'd9; ae = 4'd8;
        for (int i = 0; i < 8; i++) cyc(1, W'(16'h0300 + i), 0);
        af = 4'd8; #1 check_state();
        af = 4'd0; ae = 4'd0; #1 check_state();
        af = 4'd6; ae = 4'd2;
        while (q.size() != 0) cyc(0, '0, 1);

        // 5: FWFT shows the head word with no rd_en, rd_en pops
        cyc(1, 16'h1234, 0);
        cyc(0, '0, 0);
        cyc(1, 16'h5678, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 0);
        cyc(0, '0, 1);

        // 6: flush with a write pending, also from full
        for (int i = 0; i < 5; i++) cyc(1, W'(16'h0400 + i), 0);
        cyc(1, 16'h0777, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, W'(16'h0500 + i), 0);
        cyc(1, 16'h0888, 1, 1);
        cyc(1, 16'h0999, 0);

        // Async reset in the middle of a write burst
        cyc(1, 16'h0A01, 0);
        cyc(1, 16'h0A02, 0);
        wr_en = 1; data_in = 16'h0A03; rd_en = 0;
        #2 rst_n = 0;
        #1 check_reset_vals();
        q.delete(); last_rd = '0; m_ovf = 0; m_unf = 0;
        @(posedge clk); #1;
        check_reset_vals();
        wr_en = 0;
        #2 rst_n = 1;
        @(posedge clk); #1;
        cyc(1, 16'h0B01, 0);
        cyc(0, '0, 1);
        cyc(0, '0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
